// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART command frame parser.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

  // Start-of-frame marker that opens every command frame.
  localparam logic [7:0] SOF_DEFAULT = 8'hAA;

  // One 8N1 byte time at 9600 baud from a 50 MHz clock (10 bits x 5208 clk).
  localparam int BYTE_TIME_CYCLES = 52080;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_HOLD
  } parser_state_t;

endpackage

// File: rtl/cmd_payload_buf.sv
// Payload storage for one command frame: register array, reset to zero.
// Latency: write lands at the next clk edge; read is combinational.
// Backpressure: none; the parser gates writes while a frame is held.
module cmd_payload_buf #(
  parameter int MAX_LEN = 16,
  parameter int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [MAX_LEN];

  // Byte-wide write port; the whole array clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) mem[i] <= 8'h00;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses SOF/CMD/LEN/payload/XOR-checksum frames from a UART byte stream.
// Latency: cmd_valid and error pulses appear one cycle after the deciding byte.
// Backpressure: a held frame blocks parsing; bytes arriving meanwhile are dropped with overrun.
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] SOF            = SOF_DEFAULT,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 10 * BYTE_TIME_CYCLES,
  parameter int         LW             = $clog2(MAX_LEN + 1),
  parameter int         AW             = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic [7:0]    cmd,
  output logic [LW-1:0] len,
  input  logic [AW-1:0] pl_addr,
  output logic [7:0]    pl_data,
  output logic          err_checksum,
  output logic          err_len,
  output logic          err_timeout,
  output logic          overrun,
  output logic          busy
);

  localparam int         CW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  parser_state_t state, state_nxt;
  logic [7:0]    xor_acc;
  logic [LW-1:0] idx;
  logic [CW-1:0] tcnt;
  logic          in_frame;
  logic          timeout_hit;
  logic          buf_we;
  logic          err_checksum_nxt, err_len_nxt, err_timeout_nxt, overrun_nxt;

  // Inter-byte timer only runs while a frame is partially received.
  assign in_frame    = (state == ST_CMD) || (state == ST_LEN) ||
                       (state == ST_PAYLOAD) || (state == ST_CHK);
  // A byte in the final count cycle takes priority over the timeout.
  assign timeout_hit = in_frame && !rx_valid && (tcnt == TO_LAST);

  assign cmd_valid = (state == ST_HOLD);
  assign busy      = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode plus the error/overrun pulse requests.
  always_comb begin
    state_nxt        = state;
    buf_we           = 1'b0;
    err_checksum_nxt = 1'b0;
    err_len_nxt      = 1'b0;
    err_timeout_nxt  = 1'b0;
    overrun_nxt      = 1'b0;
    case (state)
      ST_IDLE: if (rx_valid && rx_data == SOF) state_nxt = ST_CMD;
      ST_CMD:  if (rx_valid) state_nxt = ST_LEN;
      ST_LEN: begin
        if (rx_valid) begin
          if (rx_data > MAX_LEN_B) begin
            err_len_nxt = 1'b1;
            state_nxt   = ST_IDLE;
          end else if (rx_data == 8'h00) begin
            state_nxt = ST_CHK;
          end else begin
            state_nxt = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_valid) begin
          buf_we = 1'b1;
          if ((idx + LW'(1)) == len) state_nxt = ST_CHK;
        end
      end
      ST_CHK: begin
        if (rx_valid) begin
          if (rx_data == xor_acc) begin
            state_nxt = ST_HOLD;
          end else begin
            err_checksum_nxt = 1'b1;
            state_nxt        = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        overrun_nxt = rx_valid;
        if (cmd_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (timeout_hit) begin
      err_timeout_nxt = 1'b1;
      state_nxt       = ST_IDLE;
    end
  end

  // Frame fields, running checksum, payload index and single-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd          <= 8'h00;
      len          <= '0;
      xor_acc      <= 8'h00;
      idx          <= '0;
      err_checksum <= 1'b0;
      err_len      <= 1'b0;
      err_timeout  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      err_checksum <= err_checksum_nxt;
      err_len      <= err_len_nxt;
      err_timeout  <= err_timeout_nxt;
      overrun      <= overrun_nxt;
      if (rx_valid) begin
        case (state)
          ST_CMD: begin
            cmd     <= rx_data;
            xor_acc <= rx_data;
          end
          ST_LEN: begin
            if (rx_data <= MAX_LEN_B) begin
              len     <= rx_data[LW-1:0];
              xor_acc <= xor_acc ^ rx_data;
              idx     <= '0;
            end
          end
          ST_PAYLOAD: begin
            xor_acc <= xor_acc ^ rx_data;
            idx     <= idx + LW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // Inter-byte timer: cleared by any byte and outside a partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     tcnt <= '0;
    else if (rx_valid || !in_frame) tcnt <= '0;
    else                         tcnt <= tcnt + CW'(1);
  end

  cmd_payload_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf_we),
    .wr_addr (idx[AW-1:0]),
    .wr_data (rx_data),
    .rd_addr (pl_addr),
    .rd_data (pl_data)
  );

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Frame-level controller that sits directly behind the 8N1 UART receiver and turns its byte stream into validated command frames. It hunts for a start-of-frame byte, then collects command, length, payload and XOR checksum. It enforces an inter-byte timeout and length limit, then holds each good frame in a payload buffer until the downstream command decoder accepts it through a valid/ready handshake.

## Interface
- SOF, 8'hAA: start-of-frame marker.
- MAX_LEN, 16: maximum payload bytes. Legal range 1..255.
- TIMEOUT_CYCLES, 520800: idle clk cycles allowed between bytes inside a frame (10 byte-times at 9600 baud, 50 MHz).
- LW, $clog2(MAX_LEN+1): width of the length fields.
- AW, $clog2(MAX_LEN): width of pl_addr.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  single-cycle strobe; each high cycle is one byte.
- cmd_valid  out  1  a validated frame is held.
- cmd_ready  in  1  downstream accepts the frame.
- cmd  out  8  command byte of the held frame.
- len  out  LW  payload length of the held frame.
- pl_addr  in  AW  payload read address.
- pl_data  out  8  payload byte at pl_addr. Combinational read.
- err_checksum  out  1  one-cycle pulse: checksum mismatch.
- err_len  out  1  one-cycle pulse: LEN > MAX_LEN.
- err_timeout  out  1  one-cycle pulse: inter-byte timeout.
- overrun  out  1  one-cycle pulse: byte dropped while holding a frame.
- busy  out  1  state != IDLE.

## Operation
- Frame format: SOF, CMD, LEN, LEN payload bytes, CHK.
- CHK = CMD ^ LEN ^ payload[0] ^ … ^ payload[LEN-1].
- States are IDLE, CMD, LEN, PAYLOAD, CHK and HOLD. Transitions below occur only on rx_valid, except timeout, rst and handshake.
- IDLE: byte == SOF → CMD. Any other byte is ignored silently.
- CMD: latch cmd, init running XOR → LEN.
- LEN: value > MAX_LEN → err_len, → IDLE. Value == 0 → CHK. Otherwise → PAYLOAD with index 0.
- PAYLOAD: write buffer[index], XOR in the byte, increment index. After byte LEN-1 → CHK.
- CHK: byte == running XOR → HOLD with cmd_valid = 1. Otherwise err_checksum, → IDLE.
- A SOF value received inside a frame is ordinary data. There is no resynchronisation mid-frame.
- HOLD: cmd, len and buffer contents are frozen. Every rx_valid here is dropped and pulses overrun, including in the acceptance cycle.
- HOLD + cmd_valid & cmd_ready → IDLE.
- Timeout: the counter clears on every rx_valid and in IDLE/HOLD, and counts up in CMD, LEN, PAYLOAD and CHK. When it reaches TIMEOUT_CYCLES-1 with no rx_valid: err_timeout, → IDLE. If rx_valid arrives in that same cycle, the byte wins and there is no timeout.
- Errors discard the partial frame. Buffer bytes beyond len are don't-care.
- pl_addr ≥ len yields undefined pl_data. No error is raised.

## Timing
- Reset values: every output 0, state IDLE, counters 0, buffer 0.
- Reset is honoured in any state, including mid-frame and HOLD. The held frame is lost.
- cmd_valid rises in the cycle after the rx_valid carrying CHK.
- err_* pulse in the cycle after the offending rx_valid, or after the final timeout count. Each lasts exactly 1 cycle.
- overrun pulses in the cycle after the dropped rx_valid.
- cmd_valid stays high until the handshake, then is low the next cycle.
- The earliest SOF that can be accepted is in the cycle after cmd_valid falls.
- cmd_ready while cmd_valid is low has no effect.
- Throughput: one byte per cycle is tolerated in every state, which exceeds the UART rate.

## Structure
- Package uart_pkg holds:
  - SOF_DEFAULT constant;
  - parser_state_t enum covering IDLE, CMD, LEN, PAYLOAD, CHK and HOLD;
  - the 9600-baud/50 MHz BYTE_TIME_CYCLES constant that TIMEOUT_CYCLES derives from.
- One sub-module, cmd_payload_buf:
  - MAX_LEN×8 register array;
  - synchronous write port;
  - asynchronous read port;
  - reset to 0.
- The FSM, XOR accumulator and timeout counter stay in uart_cmd_parser.

## Test plan
- Good frame: AA 10 03 01 02 03 13 → cmd_valid with cmd=0x10, len=3, pl_data at addresses 0..2 reads 01 02 03. Hold cmd_ready low 20 cycles, frame stays stable, then pulse ready → cmd_valid drops, busy=0.
- Bad checksum: AA 10 03 01 02 03 14 → err_checksum for one cycle, no cmd_valid. The following good frame is accepted normally.
- Zero length and garbage: 55 00 AA 20 00 20 → leading bytes ignored; cmd_valid with cmd=0x20, len=0.
- Length limit: MAX_LEN=16, send AA 30 11 → err_len, state IDLE. Trailing bytes ignored until the next AA.
- Timeout: TIMEOUT_CYCLES=100, send AA 10 then silence → err_timeout exactly 100 cycles after the 10 strobe. A byte landing on cycle 99 prevents the timeout.
- Overrun and reset: in HOLD, send 3 bytes → 3 overrun pulses and the frame is unchanged. Assert rst mid-PAYLOAD → all outputs 0, and the next full frame is parsed correctly.
